// File: rtl/fpu_ctrl_pkg.sv
// fpu_ctrl_pkg: encodings and operand/result bundles shared by the FPU control blocks.
package fpu_ctrl_pkg;

  localparam int FPU_SIG_PRE_W = 27;
  localparam int FPU_EXP_W     = 8;
  localparam int FPU_SIG_IN_W  = 24;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  typedef struct packed {
    logic                     is_sub;
    logic                     exp0;
    logic [FPU_EXP_W-1:0]     exp_half;
    logic [FPU_SIG_IN_W-1:0]  sig;
  } sq_op_t;

  typedef struct packed {
    logic [FPU_SIG_PRE_W-1:0] sig;
    logic [FPU_EXP_W-1:0]     exp;
    logic                     uf;
  } sq_rsp_t;

endpackage

// File: rtl/fpu_sqrt_seq.sv
// fpu_sqrt_seq: valid/ready sequencer in front of the iterative square-root datapath.
// Optional watchdog is compiled in when FPU_SQRT_WDOG_EN is defined.
module fpu_sqrt_seq
  import fpu_ctrl_pkg::*;
#(
  parameter int TAG_W    = 4,
  parameter int MIN_CYC  = 2,
  parameter int WDOG_CYC = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [TAG_W-1:0]         req_tag,
  input  logic                     req_is_subnormal,
  input  logic                     req_in_exp0,
  input  logic [FPU_EXP_W-1:0]     req_exp_half,
  input  logic [FPU_SIG_IN_W-1:0]  req_sig,
  output logic                     sq_start,
  output logic                     sq_is_subnormal,
  output logic                     sq_in_exp0,
  output logic [FPU_EXP_W-1:0]     sq_exp_half,
  output logic [FPU_SIG_IN_W-1:0]  sq_in_sig,
  input  logic                     sq_done,
  input  logic [FPU_SIG_PRE_W-1:0] sq_sig,
  input  logic [FPU_EXP_W-1:0]     sq_exp,
  input  logic                     sq_uf,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [FPU_SIG_PRE_W-1:0] rsp_sig,
  output logic [FPU_EXP_W-1:0]     rsp_exp,
  output logic                     rsp_uf,
  output logic                     busy,
  output logic                     wdog_err
);

  localparam int               CNT_W   = $clog2(MIN_CYC + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_CYC);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  sq_op_t           op_q, op_d;
  sq_rsp_t          rsp_q, rsp_d;
  logic             accept;
  logic             done_qual;
  logic             wd_trip;

  assign req_ready = !flush && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && rsp_ready));
  assign accept    = req_valid && req_ready;
  // The datapath holds done from the previous op, so it is only trusted MIN_CYC cycles after start.
  assign done_qual = sq_done && (cnt_q >= MIN_CNT) &&
                     ((state_q == ST_RUN) || (state_q == ST_DRAIN));

`ifdef FPU_SQRT_WDOG_EN
  localparam int              WD_W    = $clog2(WDOG_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wdog_err_q, wdog_err_d;
  logic            wd_active;

  assign wd_active = (state_q == ST_START) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign wd_trip   = wd_active && (wd_cnt_q == WD_LAST) && !done_qual;
  assign wdog_err  = wdog_err_q;

  always_comb begin
    wdog_err_d = wdog_err_q | wd_trip;
    if (accept) begin
      wd_cnt_d = '0;
    end else if (wd_active && !wd_trip) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end else begin
      wd_cnt_d = wd_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q   <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end
`else
  assign wd_trip  = 1'b0;
  assign wdog_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    if (accept) begin
      tag_d           = req_tag;
      op_d.is_sub     = req_is_subnormal;
      op_d.exp0       = req_in_exp0;
      op_d.exp_half   = req_exp_half;
      op_d.sig        = req_sig;
    end else begin
      tag_d = tag_q;
      op_d  = op_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_START;
        else        state_d = ST_IDLE;
      end
      ST_START: begin
        cnt_d = '0;
        if (wd_trip)    state_d = ST_IDLE;
        else if (flush) state_d = ST_DRAIN;
        else            state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (wd_trip) begin
          state_d = ST_IDLE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end else if (done_qual) begin
          rsp_d.sig = sq_sig;
          rsp_d.exp = sq_exp;
          rsp_d.uf  = sq_uf;
          state_d   = ST_HOLD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (flush)                      state_d = ST_IDLE;
        else if (rsp_ready && accept)   state_d = ST_START;
        else if (rsp_ready)             state_d = ST_IDLE;
        else                            state_d = ST_HOLD;
      end
      ST_DRAIN: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (wd_trip || done_qual) state_d = ST_IDLE;
        else                      state_d = ST_DRAIN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      op_q    <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      op_q    <= op_d;
      rsp_q   <= rsp_d;
    end
  end

  assign sq_start        = (state_q == ST_START);
  assign rsp_valid       = (state_q == ST_HOLD);
  assign busy            = (state_q != ST_IDLE);
  assign sq_is_subnormal = op_q.is_sub;
  assign sq_in_exp0      = op_q.exp0;
  assign sq_exp_half     = op_q.exp_half;
  assign sq_in_sig       = op_q.sig;
  assign rsp_tag         = tag_q;
  assign rsp_sig         = rsp_q.sig;
  assign rsp_exp         = rsp_q.exp;
  assign rsp_uf          = rsp_q.uf;

endmodule
